// File: rtl/snn_timestep_sequencer.sv
// rtl/snn_timestep_sequencer.sv - timestep sequencer for the SNN convolution layer (capture -> conv -> pool)
module snn_timestep_sequencer #(
    parameter int TS_W           = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [TS_W-1:0] num_timesteps,
    input  logic            pause,
    output logic            stage_reset,
    output logic            capture_enable,
    input  logic            capture_active,
    output logic            conv_enable,
    input  logic            conv_active,
    input  logic            conv_ready,
    output logic            pool_enable,
    input  logic            pool_active,
    input  logic            pool_done,
    output logic            conv_or_pool,
    output logic            busy,
    output logic [TS_W-1:0] timestep,
    output logic            run_done,
    output logic            error,
    output logic [1:0]      error_phase
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_CONV = 3'd3;
    localparam logic [2:0] S_POOL = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;
    localparam logic [2:0] S_ERR  = 3'd7;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      state_q, state_d;
    logic [TS_W-1:0] count_q, count_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            seen_q, seen_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic [1:0]      err_phase_q, err_phase_d;

    logic stage_reset_q, stage_reset_d;
    logic capture_enable_q, capture_enable_d;
    logic conv_enable_q, conv_enable_d;
    logic pool_enable_q, pool_enable_d;
    logic conv_or_pool_q, conv_or_pool_d;
    logic busy_q, busy_d;
    logic run_done_q, run_done_d;
    logic error_q, error_d;

    logic            active_in;
    logic            exit_ok;
    logic [1:0]      phase_code;
    logic [2:0]      phase_next;
    logic [TS_W:0]   ts_inc;

    // Per-phase view of the stage handshake: what sets seen, what ends the phase, where it goes.
    always_comb begin
        active_in  = 1'b0;
        exit_ok    = 1'b0;
        phase_code = 2'd0;
        phase_next = S_IDLE;
        case (state_q)
            S_CAP: begin
                active_in  = capture_active;
                exit_ok    = seen_q && !capture_active;
                phase_code = 2'd1;
                phase_next = S_CONV;
            end
            S_CONV: begin
                active_in  = conv_active;
                exit_ok    = seen_q && !conv_active && conv_ready;
                phase_code = 2'd2;
                phase_next = S_POOL;
            end
            S_POOL: begin
                // seen only tracks pool activity here; pool exit relies on pool_done alone
                active_in  = pool_active;
                exit_ok    = pool_done;
                phase_code = 2'd3;
                phase_next = S_NEXT;
            end
            default: ;
        endcase
    end

    assign ts_inc = {1'b0, ts_q} + {{TS_W{1'b0}}, 1'b1};

    // Sequencing: run setup, phase watchdog/exit, timestep advance and error capture.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ts_d        = ts_q;
        seen_d      = seen_q;
        wd_d        = wd_q;
        err_phase_d = err_phase_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    count_d     = num_timesteps;
                    ts_d        = '0;
                    err_phase_d = 2'd0;
                    state_d     = (num_timesteps == '0) ? S_FIN : S_RST;
                end
            end
            S_RST: begin
                state_d = S_CAP;
                seen_d  = 1'b0;
                wd_d    = '0;
            end
            S_CAP, S_CONV, S_POOL: begin
                if (!pause) begin
                    if (exit_ok) begin
                        state_d = phase_next;
                        seen_d  = 1'b0;
                        wd_d    = '0;
                    end else if (wd_q == WD_LAST) begin
                        state_d     = S_ERR;
                        err_phase_d = phase_code;
                    end else begin
                        wd_d   = wd_q + TO_W'(1);
                        seen_d = seen_q | active_in;
                    end
                end
            end
            S_NEXT: begin
                if (ts_inc == {1'b0, count_q}) begin
                    state_d = S_FIN;
                end else begin
                    ts_d    = ts_inc[TS_W-1:0];
                    state_d = S_CAP;
                    seen_d  = 1'b0;
                    wd_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from the next state so registered outputs line up with the state.
    always_comb begin
        stage_reset_d    = (state_d == S_RST);
        capture_enable_d = (state_d == S_CAP)  && !pause;
        conv_enable_d    = (state_d == S_CONV) && !pause;
        pool_enable_d    = (state_d == S_POOL) && !pause;
        conv_or_pool_d   = (state_d == S_CONV);
        busy_d           = (state_d == S_RST) || (state_d == S_CAP) || (state_d == S_CONV) ||
                           (state_d == S_POOL) || (state_d == S_NEXT);
        run_done_d       = (state_d == S_FIN);
        error_d          = (state_d == S_ERR);
    end

    // State and output registers; reset drops every output immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            count_q          <= '0;
            ts_q             <= '0;
            seen_q           <= 1'b0;
            wd_q             <= '0;
            err_phase_q      <= 2'd0;
            stage_reset_q    <= 1'b0;
            capture_enable_q <= 1'b0;
            conv_enable_q    <= 1'b0;
            pool_enable_q    <= 1'b0;
            conv_or_pool_q   <= 1'b0;
            busy_q           <= 1'b0;
            run_done_q       <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            ts_q             <= ts_d;
            seen_q           <= seen_d;
            wd_q             <= wd_d;
            err_phase_q      <= err_phase_d;
            stage_reset_q    <= stage_reset_d;
            capture_enable_q <= capture_enable_d;
            conv_enable_q    <= conv_enable_d;
            pool_enable_q    <= pool_enable_d;
            conv_or_pool_q   <= conv_or_pool_d;
            busy_q           <= busy_d;
            run_done_q       <= run_done_d;
            error_q          <= error_d;
        end
    end

    assign stage_reset    = stage_reset_q;
    assign capture_enable = capture_enable_q;
    assign conv_enable    = conv_enable_q;
    assign pool_enable    = pool_enable_q;
    assign conv_or_pool   = conv_or_pool_q;
    assign busy           = busy_q;
    assign timestep       = ts_q;
    assign run_done       = run_done_q;
    assign error          = error_q;
    assign error_phase    = err_phase_q;

endmodule

// File: tb/tb_snn_timestep_sequencer.sv
// tb/tb_snn_timestep_sequencer.sv - self-checking bench for snn_timestep_sequencer
module tb_snn_timestep_sequencer;

    localparam int TS_W = 16;
    localparam int TO   = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [TS_W-1:0] num_timesteps = '0;
    logic            pause = 1'b0;
    logic            capture_active = 1'b0;
    logic            conv_active = 1'b0;
    logic            conv_ready = 1'b0;
    logic            pool_active = 1'b0;
    logic            pool_done = 1'b0;
    logic            stage_reset, capture_enable, conv_enable, pool_enable, conv_or_pool;
    logic            busy, run_done, error;
    logic [TS_W-1:0] timestep;
    logic [1:0]      error_phase;

    always #5 clk = ~clk;

    snn_timestep_sequencer #(.TS_W(TS_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_timesteps(num_timesteps),
        .pause(pause), .stage_reset(stage_reset), .capture_enable(capture_enable),
        .capture_active(capture_active), .conv_enable(conv_enable), .conv_active(conv_active),
        .conv_ready(conv_ready), .pool_enable(pool_enable), .pool_active(pool_active),
        .pool_done(pool_done), .conv_or_pool(conv_or_pool), .busy(busy), .timestep(timestep),
        .run_done(run_done), .error(error), .error_phase(error_phase)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // stage models: active for act_len cycles after a delay, counted in enabled cycles
    int c_cap = 0, c_conv = 0, c_pool = 0;
    int cap_d = 5, conv_d = 5, pool_d = 5, act_len = 2;
    bit conv_mute = 1'b0, force_ready = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (stage_reset || !busy) begin c_cap = 0; c_conv = 0; c_pool = 0; end
            if (capture_enable) begin c_cap++;  c_pool = 0; end
            if (conv_enable)    begin c_conv++; c_cap  = 0; end
            if (pool_enable)    begin c_pool++; c_conv = 0; end
            capture_active = capture_enable && (c_cap > cap_d) && (c_cap <= cap_d + act_len);
            conv_active    = !conv_mute && conv_enable && (c_conv > conv_d) && (c_conv <= conv_d + act_len);
            conv_ready     = force_ready || (!conv_mute && (c_conv > conv_d + act_len));
            pool_done      = pool_enable && (c_pool == pool_d);
            pool_active    = pool_enable;
        end
    end

    // monitor counters
    int n_srst = 0, n_caprise = 0, n_conv_cyc = 0, n_cop_bad = 0, n_ts_bad = 0, n_done = 0;
    bit prev_cap = 1'b0, pause_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (stage_reset) n_srst++;
            if (capture_enable && !prev_cap) begin
                if (int'(timestep) != n_caprise) n_ts_bad++;
                n_caprise++;
            end
            if (conv_enable) n_conv_cyc++;
            if (conv_or_pool && !conv_enable && !pause && !pause_prev) n_cop_bad++;
            if (run_done) n_done++;
            prev_cap   = capture_enable;
            pause_prev = pause;
        end
    end

    task automatic clr();
        n_srst = 0; n_caprise = 0; n_conv_cyc = 0; n_cop_bad = 0; n_ts_bad = 0; n_done = 0;
    endtask

    task automatic do_run(input int num, input bit poke, output bit got_done, output int lat,
                          output int ts_at, output logic busy_at, output logic busy_before);
        @(posedge clk); #1; clr();
        @(negedge clk); num_timesteps = TS_W'(num); start = 1'b1;
        @(negedge clk); start = 1'b0;
        got_done = 1'b0; lat = -1; ts_at = -1; busy_at = 1'bx; busy_before = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (run_done) begin
                got_done = 1'b1; lat = i + 1; ts_at = int'(timestep); busy_at = busy;
                break;
            end
            if (poke && i == 3) begin num_timesteps = 7; start = 1'b1; end
            if (poke && i == 4) start = 1'b0;
            busy_before = busy;
            @(negedge clk);
        end
        num_timesteps = '0;
    endtask

    typedef struct {
        int num;
        bit poke;
        int exp_caps;
        int exp_ts;
        int exp_conv;
        int exp_srst;
        int exp_lat;
    } vec_t;

    vec_t vecs[5];
    bit   got_done;
    int   lat, ts_at;
    logic busy_at, busy_before;

    initial begin
        // each conv phase: 5 idle + 2 active + 1 ready cycle = 8 enabled cycles
        vecs[0] = '{num: 2, poke: 1'b0, exp_caps: 2, exp_ts: 1, exp_conv: 16, exp_srst: 1, exp_lat: -1};
        vecs[1] = '{num: 0, poke: 1'b0, exp_caps: 0, exp_ts: 0, exp_conv: 0,  exp_srst: 0, exp_lat: 1};
        vecs[2] = '{num: 3, poke: 1'b0, exp_caps: 3, exp_ts: 2, exp_conv: 24, exp_srst: 1, exp_lat: -1};
        vecs[3] = '{num: 2, poke: 1'b1, exp_caps: 2, exp_ts: 1, exp_conv: 16, exp_srst: 1, exp_lat: -1};
        vecs[4] = '{num: 1, poke: 1'b0, exp_caps: 1, exp_ts: 0, exp_conv: 8,  exp_srst: 1, exp_lat: -1};

        // reset state
        #12;
        chk("reset_outputs", 64'({stage_reset, capture_enable, conv_enable, pool_enable, conv_or_pool,
                                  busy, run_done, error, error_phase, timestep}), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // table-driven runs
        for (int k = 0; k < 5; k++) begin
            do_run(vecs[k].num, vecs[k].poke, got_done, lat, ts_at, busy_at, busy_before);
            chk($sformatf("v%0d_done", k), 64'(got_done), 64'd1);
            chk($sformatf("v%0d_timestep", k), 64'(ts_at), 64'(vecs[k].exp_ts));
            chk($sformatf("v%0d_busy_at_done", k), 64'(busy_at), 64'd0);
            chk($sformatf("v%0d_busy_before", k), 64'(busy_before), 64'(vecs[k].num > 0));
            chk($sformatf("v%0d_cap_phases", k), 64'(n_caprise), 64'(vecs[k].exp_caps));
            chk($sformatf("v%0d_conv_cycles", k), 64'(n_conv_cyc), 64'(vecs[k].exp_conv));
            chk($sformatf("v%0d_stage_reset", k), 64'(n_srst), 64'(vecs[k].exp_srst));
            chk($sformatf("v%0d_ts_seq", k), 64'(n_ts_bad), 64'd0);
            chk($sformatf("v%0d_cop_bad", k), 64'(n_cop_bad), 64'd0);
            if (vecs[k].exp_lat >= 0)
                chk($sformatf("v%0d_latency", k), 64'(lat), 64'(vecs[k].exp_lat));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", k), 64'(run_done), 64'd0);
            chk($sformatf("v%0d_done_count", k), 64'(n_done), 64'd1);
        end

        // watchdog timeout in CONV, then recovery via start
        begin
            bit found;
            @(posedge clk); #1; clr(); conv_mute = 1'b1;
            @(negedge clk); num_timesteps = 1; start = 1'b1;
            @(negedge clk); start = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (error) begin found = 1'b1; break; end
                @(negedge clk);
            end
            chk("to_error", 64'(found), 64'd1);
            chk("to_phase", 64'(error_phase), 64'd2);
            chk("to_conv_en", 64'(conv_enable), 64'd0);
            chk("to_busy", 64'(busy), 64'd0);
            chk("to_conv_cycles", 64'(n_conv_cyc), 64'(TO));
            repeat (3) @(negedge clk);
            chk("to_sticky", 64'({error, error_phase}), 64'({1'b1, 2'd2}));
            conv_mute = 1'b0;
            do_run(1, 1'b0, got_done, lat, ts_at, busy_at, busy_before);
            chk("to_recover_done", 64'(got_done), 64'd1);
            chk("to_recover_err", 64'({error, error_phase}), 64'd0);
            chk("to_recover_conv", 64'(n_conv_cyc), 64'd8);
        end

        // stale conv_ready: exit waits for the delayed active pulse to end (10 + 2 + 1)
        force_ready = 1'b1; conv_d = 10;
        do_run(1, 1'b0, got_done, lat, ts_at, busy_at, busy_before);
        chk("stale_done", 64'(got_done), 64'd1);
        chk("stale_conv_cycles", 64'(n_conv_cyc), 64'd13);
        chk("stale_err", 64'(error), 64'd0);
        force_ready = 1'b0; conv_d = 5;

        // pause 20 cycles mid-CONV
        begin
            bit hit;
            int pv;
            @(posedge clk); #1; clr();
            @(negedge clk); num_timesteps = 1; start = 1'b1;
            @(negedge clk); start = 1'b0;
            hit = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk); #1;
                if (conv_enable && c_conv == 3) begin hit = 1'b1; break; end
            end
            chk("pause_reach_conv", 64'(hit), 64'd1);
            pause = 1'b1;
            pv = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (conv_enable !== 1'b0) pv++;
                if (conv_or_pool !== 1'b1) pv++;
            end
            pause = 1'b0;
            chk("pause_outputs", 64'(pv), 64'd0);
            hit = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (run_done) begin hit = 1'b1; break; end
            end
            chk("pause_done", 64'(hit), 64'd1);
            chk("pause_no_error", 64'(error), 64'd0);
            chk("pause_conv_cycles", 64'(n_conv_cyc), 64'd8);
        end

        // asynchronous reset mid-POOL
        begin
            bit hit;
            @(posedge clk); #1; clr();
            @(negedge clk); num_timesteps = 3; start = 1'b1;
            @(negedge clk); start = 1'b0;
            hit = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (pool_enable) begin hit = 1'b1; break; end
                @(negedge clk);
            end
            chk("rst_reach_pool", 64'(hit), 64'd1);
            @(negedge clk); #2; reset_n = 1'b0; #1;
            chk("rst_async_outputs", 64'({stage_reset, capture_enable, conv_enable, pool_enable, conv_or_pool,
                                          busy, run_done, error, error_phase, timestep}), 64'd0);
            repeat (2) @(negedge clk);
            chk("rst_no_done", 64'(n_done), 64'd0);
            reset_n = 1'b1;
            repeat (2) @(negedge clk);
            chk("rst_idle", 64'({busy, capture_enable, conv_enable, pool_enable}), 64'd0);
            do_run(2, 1'b0, got_done, lat, ts_at, busy_at, busy_before);
            chk("rst_rerun_done", 64'(got_done), 64'd1);
            chk("rst_rerun_ts", 64'(ts_at), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
